// File: rtl/obsidyen_fetch_unit_pkg.sv
// Shared types for the OBSIDYEN fetch front end: FSM states, prefetch entry, reset vector.
package obsidyen_fetch_unit_pkg;

    localparam int FETCH_XLEN = 32;
    localparam logic [FETCH_XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_FLUSH
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

    // Fetch addresses are always word aligned; the low two bits are dropped.
    function automatic logic [FETCH_XLEN-1:0] pc_align(input logic [FETCH_XLEN-1:0] pc);
        return {pc[FETCH_XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/obsidyen_fetch_unit_if.sv
// Fetch unit bus bundle: imem request/response, redirect, and decode handshake.
// master = fetch unit, slave = surrounding environment (imem, branch unit, decode).
interface obsidyen_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid_o;
    logic            imem_req_ready_i;
    logic [XLEN-1:0] imem_req_addr_o;
    logic            imem_rsp_valid_i;
    logic [XLEN-1:0] imem_rsp_data_i;
    logic            redirect_valid_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic            instr_valid_o;
    logic            instr_ready_i;
    logic [XLEN-1:0] instr_o;
    logic [XLEN-1:0] instr_pc_o;

    modport master (
        output imem_req_valid_o, imem_req_addr_o, instr_valid_o, instr_o, instr_pc_o,
        input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
        input  redirect_valid_i, redirect_pc_i, instr_ready_i
    );

    modport slave (
        input  imem_req_valid_o, imem_req_addr_o, instr_valid_o, instr_o, instr_pc_o,
        output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
        output redirect_valid_i, redirect_pc_i, instr_ready_i
    );
endinterface

// File: rtl/obsidyen_fetch_unit_fifo.sv
// Prefetch FIFO of fetch_entry_t; push visible at head one cycle later, flush wins over push.
// Push when full / pop when empty are ignored; the caller's credit scheme keeps them from happening.
module obsidyen_fetch_unit_fifo
    import obsidyen_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  fetch_entry_t                 push_dat,
    output fetch_entry_t                 head_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty && !flush;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/obsidyen_fetch_unit.sv
// Decoupled fetch front end: sequential imem requests, prefetch FIFO, redirect flush; >=1 cycle rsp->instr.
// Issue is credit limited (outstanding + buffered < FIFO_DEPTH) so responses are never refused. Optional: OBS_FETCH_PERF_EN.
module obsidyen_fetch_unit
    import obsidyen_fetch_unit_pkg::*;
#(
    parameter int                    XLEN            = FETCH_XLEN,
    parameter int                    FIFO_DEPTH      = 4,
    parameter int                    MAX_OUTSTANDING = 2,
    parameter logic [FETCH_XLEN-1:0] RESET_VECTOR    = DEFAULT_RESET_VECTOR
)(
    input  logic                      clk_i,
    input  logic                      rst_i,
    obsidyen_fetch_unit_if.master     bus
`ifdef OBS_FETCH_PERF_EN
    ,
    output logic [31:0]               perf_stall_cnt_o,
    output logic [31:0]               perf_drop_cnt_o
`endif
);
    localparam int OW = $clog2(MAX_OUTSTANDING+1);
    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam int SW = CW + 1;

    fetch_state_e    state_q;
    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] rsp_pc_q;
    logic [OW-1:0]   outstanding_q;
    logic [OW-1:0]   drop_cnt_q;
    logic [OW-1:0]   outstanding_next;
    logic [OW-1:0]   drop_next;

    logic            redirect;
    logic            req_vld;
    logic            req_hs;
    logic            rsp_vld;
    logic            rsp_drop;
    logic            fifo_push;
    logic            fifo_pop;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full_unused;
    logic            fifo_empty;
    logic [SW-1:0]   credit_sum;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;

    assign redirect   = bus.redirect_valid_i;
    assign rsp_vld    = bus.imem_rsp_valid_i;
    assign credit_sum = SW'(outstanding_q) + SW'(fifo_count);

    // Every issued request owns a FIFO slot until it is consumed by decode.
    assign req_vld = (state_q != ST_BOOT) && !redirect &&
                     (outstanding_q < OW'(MAX_OUTSTANDING)) &&
                     (credit_sum < SW'(FIFO_DEPTH));
    assign req_hs  = req_vld && bus.imem_req_ready_i;

    // A response arriving with a redirect belongs to the abandoned stream.
    assign rsp_drop  = rsp_vld && (redirect || (drop_cnt_q != '0));
    assign fifo_push = rsp_vld && !rsp_drop;
    assign fifo_pop  = bus.instr_ready_i && !fifo_empty;

    assign outstanding_next = outstanding_q + OW'(req_hs) - OW'(rsp_vld);

    always_comb begin
        drop_next = drop_cnt_q;
        if (redirect) begin
            drop_next = outstanding_next;
        end else if (rsp_vld && (drop_cnt_q != '0)) begin
            drop_next = drop_cnt_q - OW'(1);
        end
    end

    assign push_entry = '{pc: rsp_pc_q, instr: bus.imem_rsp_data_i};

    obsidyen_fetch_unit_fifo #(
        .DEPTH    (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk_i),
        .rst      (rst_i),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .flush    (redirect),
        .push_dat (push_entry),
        .head_dat (head_entry),
        .count    (fifo_count),
        .full     (fifo_full_unused),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_BOOT;
            fetch_pc_q    <= RESET_VECTOR;
            rsp_pc_q      <= RESET_VECTOR;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            outstanding_q <= outstanding_next;
            drop_cnt_q    <= drop_next;
            case (state_q)
                ST_BOOT:          state_q <= ST_RUN;
                ST_RUN, ST_FLUSH: state_q <= (drop_next != '0) ? ST_FLUSH : ST_RUN;
                default:          state_q <= ST_BOOT;
            endcase
            if (redirect) begin
                fetch_pc_q <= pc_align(bus.redirect_pc_i);
                rsp_pc_q   <= pc_align(bus.redirect_pc_i);
            end else begin
                if (req_hs)    fetch_pc_q <= fetch_pc_q + XLEN'(4);
                if (fifo_push) rsp_pc_q   <= rsp_pc_q + XLEN'(4);
            end
        end
    end

    // Address is zeroed while idle so every output reads 0 out of reset.
    assign bus.imem_req_valid_o = req_vld;
    assign bus.imem_req_addr_o  = req_vld ? fetch_pc_q : '0;
    assign bus.instr_valid_o    = !fifo_empty;
    assign bus.instr_o          = fifo_empty ? '0 : head_entry.instr;
    assign bus.instr_pc_o       = fifo_empty ? '0 : head_entry.pc;

`ifdef OBS_FETCH_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] drop_cnt_perf_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q     <= '0;
            drop_cnt_perf_q <= '0;
        end else begin
            if ((state_q != ST_BOOT) && fifo_empty && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (rsp_drop && (drop_cnt_perf_q != '1)) begin
                drop_cnt_perf_q <= drop_cnt_perf_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt_o = stall_cnt_q;
    assign perf_drop_cnt_o  = drop_cnt_perf_q;
`endif
endmodule

// File: tb/tb_obsidyen_fetch_unit.sv
// Directed bench for obsidyen_fetch_unit with an in-order imem model (1-cycle latency, gateable).
module tb_obsidyen_fetch_unit;
    import obsidyen_fetch_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    obsidyen_fetch_unit_if #(.XLEN(32)) bus ();

`ifdef OBS_FETCH_PERF_EN
    logic [31:0] perf_stall;
    logic [31:0] perf_drop;
`endif

    obsidyen_fetch_unit #(
        .XLEN            (32),
        .FIFO_DEPTH      (4),
        .MAX_OUTSTANDING (2),
        .RESET_VECTOR    (32'h0000_0000)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
`ifdef OBS_FETCH_PERF_EN
        ,
        .perf_stall_cnt_o (perf_stall),
        .perf_drop_cnt_o  (perf_drop)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    logic        rsp_en = 1'b1;
    logic [31:0] pend_q [$];
    logic [31:0] req_q  [$];
    logic [63:0] got_q  [$];
    logic        s_rst    = 1'b1;
    logic        s_hs     = 1'b0;
    logic        s_rsp    = 1'b0;
    logic        s_rsp_en = 1'b0;
    logic [31:0] s_addr   = '0;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    // Sample everything mid-cycle, away from the active edge.
    always @(negedge clk) begin
        s_rst    = rst;
        s_rsp_en = rsp_en;
        s_hs     = !rst && bus.imem_req_valid_o && bus.imem_req_ready_i;
        s_rsp    = !rst && bus.imem_rsp_valid_i;
        s_addr   = bus.imem_req_addr_o;
        if (s_hs) req_q.push_back(s_addr);
        if (!rst && bus.instr_valid_o && bus.instr_ready_i)
            got_q.push_back({bus.instr_pc_o, bus.instr_o});
    end

    always @(posedge clk) begin
        #1;
        if (s_rst) begin
            pend_q.delete();
        end else begin
            if (s_rsp && pend_q.size() > 0) void'(pend_q.pop_front());
            if (s_hs) pend_q.push_back(s_addr);
        end
        if (!s_rst && s_rsp_en && pend_q.size() > 0) begin
            bus.imem_rsp_valid_i = 1'b1;
            bus.imem_rsp_data_i  = imem_word(pend_q[0]);
        end else begin
            bus.imem_rsp_valid_i = 1'b0;
            bus.imem_rsp_data_i  = '0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] got_pc(input int i);
        logic [63:0] e;
        if (i >= got_q.size()) return 32'hBAD0_BAD0;
        e = got_q[i];
        return e[63:32];
    endfunction

    function automatic logic [31:0] got_ins(input int i);
        logic [63:0] e;
        if (i >= got_q.size()) return 32'hBAD0_BAD0;
        e = got_q[i];
        return e[31:0];
    endfunction

    function automatic logic [31:0] rq(input int i);
        if (i >= req_q.size()) return 32'hBAD0_BAD0;
        return req_q[i];
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        req_q.delete();
        got_q.delete();
    endtask

    initial begin
        bus.imem_req_ready_i = 1'b1;
        bus.redirect_valid_i = 1'b0;
        bus.redirect_pc_i    = '0;
        bus.instr_ready_i    = 1'b1;
        bus.imem_rsp_valid_i = 1'b0;
        bus.imem_rsp_data_i  = '0;

        // Reset state: every output low.
        repeat (2) tick();
        settle();
        chk("rst_req_valid",   64'(bus.imem_req_valid_o), 64'd0);
        chk("rst_req_addr",    64'(bus.imem_req_addr_o),  64'd0);
        chk("rst_instr_valid", 64'(bus.instr_valid_o),    64'd0);
        chk("rst_instr",       64'(bus.instr_o),          64'd0);
        chk("rst_instr_pc",    64'(bus.instr_pc_o),       64'd0);

        // 1: sequential stream.
        do_reset();
        settle();
        chk("t1_boot_no_req", 64'(bus.imem_req_valid_o), 64'd0);
        tick();
        settle();
        chk("t1_first_req_vld",  64'(bus.imem_req_valid_o), 64'd1);
        chk("t1_first_req_addr", 64'(bus.imem_req_addr_o),  64'd0);
        repeat (10) tick();
        chk("t1_req0", 64'(rq(0)), 64'h0);
        chk("t1_req1", 64'(rq(1)), 64'h4);
        chk("t1_req2", 64'(rq(2)), 64'h8);
        chk("t1_pc0",  64'(got_pc(0)), 64'h0);
        chk("t1_pc1",  64'(got_pc(1)), 64'h4);
        chk("t1_pc2",  64'(got_pc(2)), 64'h8);
        chk("t1_ins0", 64'(got_ins(0)), 64'(imem_word(32'h0)));
        chk("t1_ins2", 64'(got_ins(2)), 64'(imem_word(32'h8)));

        // 2: decode stalled, credit limits issue to FIFO_DEPTH.
        bus.instr_ready_i = 1'b0;
        do_reset();
        repeat (20) tick();
        settle();
        chk("t2_req_count",   64'(req_q.size()), 64'd4);
        chk("t2_none_popped", 64'(got_q.size()), 64'd0);
        chk("t2_req_blocked", 64'(bus.imem_req_valid_o), 64'd0);
        chk("t2_head_valid",  64'(bus.instr_valid_o), 64'd1);
        chk("t2_head_pc",     64'(bus.instr_pc_o), 64'h0);
        chk("t2_head_ins",    64'(bus.instr_o), 64'(imem_word(32'h0)));
        tick();
        bus.instr_ready_i = 1'b1;
        repeat (12) tick();
        chk("t2_pc0", 64'(got_pc(0)), 64'h0);
        chk("t2_pc1", 64'(got_pc(1)), 64'h4);
        chk("t2_pc2", 64'(got_pc(2)), 64'h8);
        chk("t2_pc3", 64'(got_pc(3)), 64'hC);
        chk("t2_resume_addr", 64'(rq(4)), 64'h10);

        // 3: redirect with two outstanding requests.
        rsp_en = 1'b0;
        do_reset();
        repeat (6) tick();
        settle();
        chk("t3_two_issued",    64'(req_q.size()), 64'd2);
        chk("t3_max_out_block", 64'(bus.imem_req_valid_o), 64'd0);
        tick();
        bus.redirect_valid_i = 1'b1;
        bus.redirect_pc_i    = 32'h0000_0102;
        settle();
        chk("t3_redirect_no_req", 64'(bus.imem_req_valid_o), 64'd0);
        tick();
        bus.redirect_valid_i = 1'b0;
        rsp_en = 1'b1;
        repeat (12) tick();
        chk("t3_first_pc",   64'(got_pc(0)), 64'h100);
        chk("t3_first_ins",  64'(got_ins(0)), 64'(imem_word(32'h100)));
        chk("t3_second_pc",  64'(got_pc(1)), 64'h104);
        chk("t3_new_req",    64'(rq(2)), 64'h100);

        // 4: redirect coinciding with a response (one still in flight).
        rsp_en = 1'b0;
        do_reset();
        repeat (6) tick();
        rsp_en = 1'b1;
        tick();
        bus.redirect_valid_i = 1'b1;
        bus.redirect_pc_i    = 32'h0000_0200;
        tick();
        bus.redirect_valid_i = 1'b0;
        repeat (12) tick();
        chk("t4_first_pc",  64'(got_pc(0)), 64'h200);
        chk("t4_first_ins", 64'(got_ins(0)), 64'(imem_word(32'h200)));
        chk("t4_second_pc", 64'(got_pc(1)), 64'h204);
        chk("t4_new_req",   64'(rq(2)), 64'h200);

        // 4b: redirect flushes a full FIFO.
        bus.instr_ready_i = 1'b0;
        do_reset();
        repeat (10) tick();
        bus.redirect_valid_i = 1'b1;
        bus.redirect_pc_i    = 32'h0000_0300;
        tick();
        bus.redirect_valid_i = 1'b0;
        settle();
        chk("t4b_flushed",  64'(bus.instr_valid_o), 64'd0);
        chk("t4b_req_vld",  64'(bus.imem_req_valid_o), 64'd1);
        chk("t4b_req_addr", 64'(bus.imem_req_addr_o), 64'h300);
        tick();
        bus.instr_ready_i = 1'b1;
        repeat (10) tick();
        chk("t4b_first_pc", 64'(got_pc(0)), 64'h300);

        // 5: imem stalls, request held stable.
        bus.imem_req_ready_i = 1'b0;
        do_reset();
        tick();
        for (int i = 0; i < 5; i++) begin
            settle();
            chk($sformatf("t5_hold_vld%0d", i),  64'(bus.imem_req_valid_o), 64'd1);
            chk($sformatf("t5_hold_addr%0d", i), 64'(bus.imem_req_addr_o),  64'h0);
            tick();
        end
        bus.imem_req_ready_i = 1'b1;
        tick();
        bus.imem_req_ready_i = 1'b0;
        settle();
        chk("t5_one_hs",    64'(req_q.size()), 64'd1);
        chk("t5_next_addr", 64'(bus.imem_req_addr_o), 64'h4);
        chk("t5_next_vld",  64'(bus.imem_req_valid_o), 64'd1);
        bus.imem_req_ready_i = 1'b1;

        // 6: reset mid-stream (3 buffered, 1 outstanding).
        bus.instr_ready_i = 1'b0;
        do_reset();
        repeat (4) tick();
        settle();
        chk("t6_head_pc", 64'(bus.instr_pc_o), 64'h0);
        tick();
        chk("t6_issued", 64'(req_q.size()), 64'd4);
        rst = 1'b1;
        tick();
        settle();
        chk("t6_req_vld",     64'(bus.imem_req_valid_o), 64'd0);
        chk("t6_req_addr",    64'(bus.imem_req_addr_o),  64'd0);
        chk("t6_instr_valid", 64'(bus.instr_valid_o),    64'd0);
        chk("t6_instr",       64'(bus.instr_o),          64'd0);
        chk("t6_instr_pc",    64'(bus.instr_pc_o),       64'd0);
        tick();
        rst = 1'b0;
        req_q.delete();
        got_q.delete();
        bus.instr_ready_i = 1'b1;
        repeat (10) tick();
        chk("t6_restart_req", 64'(rq(0)), 64'h0);
        chk("t6_restart_pc",  64'(got_pc(0)), 64'h0);
        chk("t6_restart_ins", 64'(got_ins(0)), 64'(imem_word(32'h0)));

        // 7: redirect during boot, unaligned target, PC wrap.
        do_reset();
        bus.redirect_valid_i = 1'b1;
        bus.redirect_pc_i    = 32'hFFFF_FFFF;
        tick();
        bus.redirect_valid_i = 1'b0;
        repeat (10) tick();
        chk("t7_req0", 64'(rq(0)), 64'hFFFF_FFFC);
        chk("t7_req1", 64'(rq(1)), 64'h0);
        chk("t7_pc0",  64'(got_pc(0)), 64'hFFFF_FFFC);
        chk("t7_pc1",  64'(got_pc(1)), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
